// File: rtl/tx_arbiter_if.sv
// Bundle of request, serializer and reply-tracking signals around tx_arbiter.
// The arbiter connects through the master modport; the scheduler, prefetcher,
// serializer and deserializer side connects through the slave modport.
interface tx_arbiter_if #(
  parameter int NSHIFT   = 2,
  parameter int CMD_BITS = 2
);
  // Scheduler requester
  logic                sched_cmd_valid;
  logic [CMD_BITS-1:0] sched_cmd;
  logic                sched_reply_wanted;
  logic                sched_reserve;
  logic [NSHIFT-1:0]   sched_tx_data;
  logic                sched_started;
  logic                sched_data_next;

  // Prefetch requester
  logic                pf_cmd_valid;
  logic [CMD_BITS-1:0] pf_cmd;
  logic [NSHIFT-1:0]   pf_tx_data;
  logic                pf_started;
  logic                pf_data_next;

  // TX serializer
  logic                tx_command_valid;
  logic [CMD_BITS-1:0] tx_command;
  logic                tx_command_started;
  logic [NSHIFT-1:0]   tx_data;
  logic                tx_data_next;
  logic                tx_done;

  // RX deserializer / reply steering
  logic                rx_done;
  logic                rx_for_sched;
  logic                rx_tag_valid;
  logic                rx_unexpected;

  modport master (
    input  sched_cmd_valid, sched_cmd, sched_reply_wanted, sched_reserve, sched_tx_data,
    output sched_started, sched_data_next,
    input  pf_cmd_valid, pf_cmd, pf_tx_data,
    output pf_started, pf_data_next,
    output tx_command_valid, tx_command, tx_data,
    input  tx_command_started, tx_data_next, tx_done,
    input  rx_done,
    output rx_for_sched, rx_tag_valid, rx_unexpected
  );

  modport slave (
    output sched_cmd_valid, sched_cmd, sched_reply_wanted, sched_reserve, sched_tx_data,
    input  sched_started, sched_data_next,
    output pf_cmd_valid, pf_cmd, pf_tx_data,
    input  pf_started, pf_data_next,
    input  tx_command_valid, tx_command, tx_data,
    output tx_command_started, tx_data_next, tx_done,
    output rx_done,
    input  rx_for_sched, rx_tag_valid, rx_unexpected
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the serial TX command channel between the instruction
// scheduler and the PC prefetcher. One owner is locked per transaction, the
// serializer's data strobes are routed to that owner, and an in-order tag FIFO
// records which requester each outstanding read reply belongs to.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to replace fixed scheduler
// priority with alternating priority between the two requesters.
module tx_arbiter #(
  parameter int NSHIFT          = 2,
  parameter int CMD_BITS        = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic        clk,
  input logic        rst_n,
  tx_arbiter_if.master bus
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OFFERED = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  // 1 = scheduler. Holds the offered winner in OFFERED and the owner in BUSY.
  logic             owner_sched_reg;
  logic             owner_sched_next;

  logic             tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             unexpected_reg;

  // ---------------------------------------------------------------------------
  // Eligibility and winner selection
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic sched_elig;
  logic pf_elig;
  logic pf_first;
  logic pick_sched;
  logic pick_pf;
  logic has_winner;

  assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_reg == '0);

  // A scheduler command that needs no reply never consumes a tag slot, so it
  // may go ahead even while the reply FIFO is full.
  assign sched_elig = bus.sched_cmd_valid && (!fifo_full || !bus.sched_reply_wanted);
  // Prefetches always expect a reply, and a scheduler reservation holds them off.
  assign pf_elig    = bus.pf_cmd_valid && !fifo_full && !bus.sched_reserve;

`ifdef ARB_ROUND_ROBIN_EN
  // Priority goes to whichever requester was not served by the last accepted
  // command; with alternating traffic this toggles on every acceptance.
  logic prio_pf_reg;
  logic accept_rr;

  assign pf_first = prio_pf_reg;

  // Remember who was served last so the other side wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_pf_reg <= 1'b0;
    end else if (accept_rr) begin
      prio_pf_reg <= owner_sched_next;
    end
  end
`else
  // Fixed priority: the scheduler always wins a tie.
  assign pf_first = 1'b0;
`endif

  assign pick_sched = sched_elig && !(pf_first && pf_elig);
  assign pick_pf    = pf_elig && !pick_sched;
  assign has_winner = pick_sched || pick_pf;

  // ---------------------------------------------------------------------------
  // Offer / accept datapath
  // ---------------------------------------------------------------------------
  logic offering;
  logic cur_sched;
  logic accept;
  logic winner_wants_reply;
  logic push;
  logic pop;
  logic data_from_sched;
  logic busy;

  assign busy     = (state_reg == ST_BUSY);
  assign offering = ((state_reg == ST_IDLE) && has_winner) || (state_reg == ST_OFFERED);

  // In IDLE the live pick is used; once offered or busy the grant is frozen.
  assign cur_sched = (state_reg == ST_IDLE) ? pick_sched : owner_sched_reg;

  // Header acceptance is only meaningful while a command is on offer; any
  // started strobe during BUSY is ignored.
  assign accept = offering && bus.tx_command_started;

  assign winner_wants_reply = cur_sched ? bus.sched_reply_wanted : 1'b1;
  assign push = accept && winner_wants_reply;
  assign pop  = bus.rx_done && !fifo_empty;

  // Payload source: the candidate in IDLE (scheduler if nobody is asking),
  // otherwise the locked owner.
  assign data_from_sched = (state_reg == ST_IDLE) ? !pick_pf : owner_sched_reg;

  assign bus.tx_command_valid = offering;
  assign bus.tx_command       = offering ? (cur_sched ? bus.sched_cmd : bus.pf_cmd)
                                         : '0;
  assign bus.sched_started    = accept && cur_sched;
  assign bus.pf_started       = accept && !cur_sched;

  assign bus.sched_data_next  = busy && owner_sched_reg  && bus.tx_data_next;
  assign bus.pf_data_next     = busy && !owner_sched_reg && bus.tx_data_next;

  // Bitwise payload mux so each serial lane is selected independently.
  generate
    for (genvar gi = 0; gi < NSHIFT; gi++) begin : g_data_mux
      assign bus.tx_data[gi] = data_from_sched ? bus.sched_tx_data[gi]
                                               : bus.pf_tx_data[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  // Next-state and grant-lock logic for IDLE -> OFFERED -> BUSY -> IDLE.
  always_comb begin
    state_next       = state_reg;
    owner_sched_next = owner_sched_reg;
    case (state_reg)
      ST_IDLE: begin
        if (has_winner) begin
          owner_sched_next = pick_sched;
          state_next       = bus.tx_command_started ? ST_BUSY : ST_OFFERED;
        end
      end
      ST_OFFERED: begin
        if (bus.tx_command_started) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.tx_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  assign accept_rr = accept;
`endif

  // Register the FSM state and the locked grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      owner_sched_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_sched_reg <= owner_sched_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Reply-owner tag FIFO
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Tag storage: write the winner's identity at the tail on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem[i] <= 1'b0;
      end
    end else if (push) begin
      tag_mem[wr_ptr_reg] <= cur_sched;
    end
  end

  // Pointers and occupancy; a push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky flag for a reply that arrived with no outstanding read to own it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unexpected_reg <= 1'b0;
    end else if (bus.rx_done && fifo_empty) begin
      unexpected_reg <= 1'b1;
    end
  end

  assign bus.rx_tag_valid  = !fifo_empty;
  assign bus.rx_for_sched  = !fifo_empty && tag_mem[rd_ptr_reg];
  assign bus.rx_unexpected = unexpected_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed testbench for tx_arbiter: a table of per-cycle stimulus/expected
// records walked in order, followed by hand-written multi-cycle sequences.
module tb_tx_arbiter;

  logic clk;
  logic rst_n;

  tx_arbiter_if #(.NSHIFT(2), .CMD_BITS(2)) bus ();

  tx_arbiter #(.NSHIFT(2), .CMD_BITS(2), .MAX_OUTSTANDING(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sv;
    logic [1:0] scmd;
    logic       srw;
    logic       sres;
    logic       pv;
    logic [1:0] pcmd;
    logic       st;
    logic       dn;
    logic       td;
    logic       rxd;
  } in_t;

  typedef struct packed {
    logic       cv;
    logic [1:0] cmd;
    logic       ss;
    logic       ps;
    logic       sdn;
    logic       pdn;
    logic [1:0] dat;
    logic       tv;
    logic       fs;
    logic       unx;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic in_t mi(input logic sv, input logic [1:0] scmd, input logic srw,
                             input logic sres, input logic pv, input logic [1:0] pcmd,
                             input logic st, input logic dn, input logic td, input logic rxd);
    in_t r;
    r.sv = sv; r.scmd = scmd; r.srw = srw; r.sres = sres; r.pv = pv; r.pcmd = pcmd;
    r.st = st; r.dn = dn; r.td = td; r.rxd = rxd;
    return r;
  endfunction

  function automatic out_t mo(input logic cv, input logic [1:0] cmd, input logic ss,
                              input logic ps, input logic sdn, input logic pdn,
                              input logic [1:0] dat, input logic tv, input logic fs,
                              input logic unx);
    out_t r;
    r.cv = cv; r.cmd = cmd; r.ss = ss; r.ps = ps; r.sdn = sdn; r.pdn = pdn;
    r.dat = dat; r.tv = tv; r.fs = fs; r.unx = unx;
    return r;
  endfunction

  task automatic add_vec(input string n, input in_t i, input out_t o);
    vec_t v;
    v.name = n; v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  // Payloads are fixed and distinct so the tx_data mux is always observable:
  // scheduler = 2'b10, prefetch = 2'b01.
  task automatic drive(input in_t i);
    bus.sched_cmd_valid    = i.sv;
    bus.sched_cmd          = i.scmd;
    bus.sched_reply_wanted = i.srw;
    bus.sched_reserve      = i.sres;
    bus.sched_tx_data      = 2'b10;
    bus.pf_cmd_valid       = i.pv;
    bus.pf_cmd             = i.pcmd;
    bus.pf_tx_data         = 2'b01;
    bus.tx_command_started = i.st;
    bus.tx_data_next       = i.dn;
    bus.tx_done            = i.td;
    bus.rx_done            = i.rxd;
  endtask

  function automatic out_t sample();
    out_t r;
    r.cv  = bus.tx_command_valid;
    r.cmd = bus.tx_command;
    r.ss  = bus.sched_started;
    r.ps  = bus.pf_started;
    r.sdn = bus.sched_data_next;
    r.pdn = bus.pf_data_next;
    r.dat = bus.tx_data;
    r.tv  = bus.rx_tag_valid;
    r.fs  = bus.rx_for_sched;
    r.unx = bus.rx_unexpected;
    return r;
  endfunction

  task automatic compare(input string n, input out_t e);
    out_t a;
    a = sample();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got cv=%b cmd=%b ss=%b ps=%b sdn=%b pdn=%b dat=%b tv=%b fs=%b unx=%b, expected cv=%b cmd=%b ss=%b ps=%b sdn=%b pdn=%b dat=%b tv=%b fs=%b unx=%b",
               n, a.cv, a.cmd, a.ss, a.ps, a.sdn, a.pdn, a.dat, a.tv, a.fs, a.unx,
               e.cv, e.cmd, e.ss, e.ps, e.sdn, e.pdn, e.dat, e.tv, e.fs, e.unx);
    end else begin
      $display("ok   %s", n);
    end
  endtask

  // Called at a negative edge: drive, let combinational paths settle, check,
  // then move on to the next negative edge (one rising edge in between).
  task automatic apply(input string n, input in_t i, input out_t e);
    drive(i);
    #1;
    compare(n, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  in_t  idle_in;
  out_t idle_out;

  initial begin
    rst_n = 1'b0;
    idle_in  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_out = mo(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0);

    //        name                      sv scmd srw sres pv pcmd st dn td rxd     cv cmd ss ps sdn pdn dat tv fs unx
    add_vec("reset_idle",           mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    add_vec("pf_accept_same_cycle", mi(0, 0, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 1, 0, 1, 0, 0, 1, 0, 0, 0));
    add_vec("pf_busy_data_next",    mi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mo(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    add_vec("busy_ignores_started", mi(1, 3, 1, 0, 0, 0, 1, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add_vec("pf_tx_done",           mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add_vec("both_valid_sched_wins",mi(1, 3, 0, 0, 1, 1, 0, 0, 0, 0), mo(1, 3, 0, 0, 0, 0, 2, 1, 0, 0));
    add_vec("sched_offer_accept",   mi(1, 3, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 3, 1, 0, 0, 0, 2, 1, 0, 0));
    add_vec("sched_busy_data_next", mi(0, 0, 0, 0, 1, 1, 0, 1, 0, 0), mo(0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    add_vec("sched_tx_done",        mi(0, 0, 0, 0, 1, 1, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    add_vec("pf_offered",           mi(0, 0, 0, 0, 1, 1, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    add_vec("offer_locked_vs_sched",mi(1, 3, 1, 0, 1, 1, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    add_vec("offer_locked_accept",  mi(1, 3, 1, 0, 1, 1, 1, 0, 0, 0), mo(1, 1, 0, 1, 0, 0, 1, 1, 0, 0));
    add_vec("pf_busy2_data_next",   mi(1, 3, 1, 0, 0, 0, 0, 1, 0, 0), mo(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    add_vec("pf_tx_done2",          mi(1, 3, 1, 0, 0, 0, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    add_vec("full_blocks_reads",    mi(1, 3, 1, 0, 1, 1, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    add_vec("full_sched_no_reply",  mi(1, 2, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 2, 1, 0, 0, 0, 2, 1, 0, 0));
    add_vec("rx_pop_while_busy",    mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    add_vec("rx_pop_last",          mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    add_vec("rx_pop_empty",         mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    add_vec("rx_unexpected_sticky", mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 2, 0, 0, 1));

    do_reset();
    foreach (vecs[k]) begin
      apply(vecs[k].name, vecs[k].i, vecs[k].o);
    end

    // Reservation holds off prefetch for 10 cycles; release offers at once.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      apply($sformatf("reserve_blocks_pf_%0d", c), mi(0, 0, 0, 1, 1, 1, 0, 0, 0, 0),
            mo(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    end
    apply("reserve_released_offer", mi(0, 0, 0, 0, 1, 1, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    apply("reserve_released_accept",mi(0, 0, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 1, 0, 1, 0, 0, 1, 0, 0, 0));

    // FIFO ordering: pf read then scheduler read fill it; a third read waits.
    apply("order_pf_done",          mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    apply("order_sched_read",       mi(1, 3, 1, 0, 0, 0, 1, 0, 0, 0), mo(1, 3, 1, 0, 0, 0, 2, 1, 0, 0));
    apply("order_sched_done",       mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    apply("order_third_pf_blocked", mi(0, 0, 0, 0, 1, 2, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    apply("order_third_pf_no_start",mi(0, 0, 0, 0, 1, 2, 1, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    apply("order_head_pf",          mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    apply("order_head_sched",       mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
    apply("order_third_rx_done",    mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    apply("order_unexpected_set",   idle_in, mo(0, 0, 0, 0, 0, 0, 2, 0, 0, 1));

    // Push and pop in the same cycle keep one entry, now the scheduler's.
    do_reset();
    apply("pp_pf_read",             mi(0, 0, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 1, 0, 1, 0, 0, 1, 0, 0, 0));
    apply("pp_pf_done",             mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    apply("pp_sched_read_and_pop",  mi(1, 3, 1, 0, 0, 0, 1, 0, 0, 1), mo(1, 3, 1, 0, 0, 0, 2, 1, 0, 0));
    apply("pp_head_now_sched",      mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
    apply("pp_pop_single",          mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mo(0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
    apply("pp_empty_no_unexpected", idle_in, idle_out);

    // Asynchronous reset in the middle of a prefetch transaction.
    do_reset();
    apply("ar_pf_read",             mi(0, 0, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 1, 0, 1, 0, 0, 1, 0, 0, 0));
    apply("ar_busy_data_next",      mi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), mo(0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    compare("ar_reset_immediate", idle_out);
    @(negedge clk);
    rst_n = 1'b1;
    apply("ar_idle_after_reset",    mi(0, 0, 0, 0, 1, 1, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));

    // Back-to-back ties: the second tie depends on the priority scheme.
    do_reset();
    apply("tie1_sched",             mi(1, 3, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 3, 1, 0, 0, 0, 2, 0, 0, 0));
    apply("tie1_done",              mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), idle_out);
`ifdef ARB_ROUND_ROBIN_EN
    apply("tie2_rr_pf",             mi(1, 3, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 1, 0, 1, 0, 0, 1, 0, 0, 0));
`else
    apply("tie2_fixed_sched",       mi(1, 3, 0, 0, 1, 1, 1, 0, 0, 0), mo(1, 3, 1, 0, 0, 0, 2, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
